// File: rtl/data_port_arbiter.sv
// Data-side BRAM port arbiter between the RS5 core (CPU) and a DMA/bootloader
// master. Grants combinationally, bounds CPU-side and DMA-side starvation, and
// routes one-cycle-latency read data back to the requester that issued it.
module data_port_arbiter #(
  parameter int unsigned MAX_CPU_STREAK = 4,  // 1..15
  parameter int unsigned MAX_DMA_BURST  = 8   // 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en_i,
  input  logic [3:0]  cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_rvalid_o,
  output logic        cpu_stall_o,
  input  logic        dma_en_i,
  input  logic        dma_lock_i,
  input  logic [3:0]  dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic [31:0] dma_rdata_o,
  output logic        dma_rvalid_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_DMA_BURST);

  typedef enum logic {ARB, DMA_BURST} state_t;

  state_t      state, state_next;
  logic [3:0]  cpu_streak, streak_next;
  logic [7:0]  burst_cnt, burst_next;
  logic        release_q, release_next;
  logic        tag_valid, tag_dma;
  logic        cpu_gnt, dma_gnt;

  // Ownership decision for the current cycle.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (cpu_en_i && dma_en_i) begin
      if (state == DMA_BURST)             dma_gnt = 1'b1;
      else if (release_q)                 cpu_gnt = 1'b1;
      else if (cpu_streak < STREAK_MAX)   cpu_gnt = 1'b1;
      else                                dma_gnt = 1'b1;
    end else if (cpu_en_i) begin
      cpu_gnt = 1'b1;
    end else if (dma_en_i) begin
      dma_gnt = 1'b1;
    end
  end

  assign cpu_stall_o = cpu_en_i & ~cpu_gnt;
  assign dma_gnt_o   = dma_gnt;

  // Memory port mux; all-zero when nobody owns the port.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end else if (dma_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = dma_we_i;
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_wdata_i;
    end
  end

  // Next-state, streak counter, burst counter and release flag.
  always_comb begin
    state_next   = state;
    burst_next   = burst_cnt;
    release_next = 1'b0;
    streak_next  = cpu_streak;

    if (dma_gnt || !dma_en_i)
      streak_next = '0;
    else if (cpu_gnt && cpu_streak != '1)
      streak_next = cpu_streak + 4'd1;

    case (state)
      ARB: begin
        if (dma_gnt && dma_lock_i && BURST_MAX > 8'd1) begin
          state_next = DMA_BURST;
          burst_next = 8'd1;
        end
      end
      DMA_BURST: begin
        if (!dma_gnt) begin
          state_next = ARB;
        end else begin
          if (burst_cnt != '1)
            burst_next = burst_cnt + 8'd1;
          // Limit exit hands the next cycle to the CPU; unlock exit does not.
          if (burst_next >= BURST_MAX) begin
            state_next   = ARB;
            release_next = 1'b1;
          end else if (!dma_lock_i) begin
            state_next = ARB;
          end
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB;
      cpu_streak <= '0;
      burst_cnt  <= '0;
      release_q  <= 1'b0;
    end else begin
      state      <= state_next;
      cpu_streak <= streak_next;
      burst_cnt  <= burst_next;
      release_q  <= release_next;
    end
  end

  // One-deep read tag: remembers who issued the read granted last cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= 1'b0;
      tag_dma   <= 1'b0;
    end else begin
      tag_valid <= (cpu_gnt | dma_gnt) & (mem_we_o == '0);
      tag_dma   <= dma_gnt;
    end
  end

  assign cpu_rvalid_o = tag_valid & ~tag_dma;
  assign dma_rvalid_o = tag_valid & tag_dma;
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
  assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Shares the single data-side BRAM port between two masters: the RS5 core data interface (CPU) and a DMA/bootloader master (DMA).
- Sits between the core's mem_* outputs and the BRAM port B / region decoder.
- Decides ownership every cycle and stalls the losing CPU access.
- Returns read data one cycle after grant, tagged to the requester that issued it.
- Bounds starvation in both directions with counters and a burst-lock state machine.

Parameters:
- MAX_CPU_STREAK, 4: consecutive CPU wins while DMA waits before DMA is forced a slot (1..15).
- MAX_DMA_BURST, 8: maximum consecutive locked DMA grants before ownership is released (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_en_i  in  1  CPU access request (mem_operation_enable)
- cpu_we_i  in  4  CPU byte write enables; 0 = read
- cpu_addr_i  in  32  CPU address
- cpu_wdata_i  in  32  CPU write data
- cpu_rdata_o  out  32  CPU read data
- cpu_rvalid_o  out  1  CPU read data valid
- cpu_stall_o  out  1  CPU must hold its request
- dma_en_i  in  1  DMA access request
- dma_lock_i  in  1  DMA asks to keep ownership for the next beat
- dma_we_i  in  4  DMA byte write enables
- dma_addr_i  in  32  DMA address
- dma_wdata_i  in  32  DMA write data
- dma_gnt_o  out  1  DMA access accepted this cycle
- dma_rdata_o  out  32  DMA read data
- dma_rvalid_o  out  1  DMA read data valid
- mem_en_o  out  1  memory port enable
- mem_we_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid one cycle after mem_en_o

Behaviour:
- Grant is combinational in the request cycle.
- At most one grant per cycle. mem_* is driven from the granted master; all mem_* outputs are 0 when there is no grant.
- cpu_gnt is internal. cpu_stall_o = cpu_en_i & ~cpu_gnt. dma_gnt_o = dma_en_i & dma selected.
- Single requester: that requester is always granted.
- Both requesting, in state ARB:
  - CPU wins if cpu_streak < MAX_CPU_STREAK.
  - Otherwise DMA wins.
- Both requesting, in state DMA_BURST: DMA wins.
- cpu_streak:
  - Increments, saturating, on each CPU grant while dma_en_i=1.
  - Cleared on any DMA grant or any cycle with dma_en_i=0.
- State machine, states ARB and DMA_BURST:
  - ARB -> DMA_BURST when DMA is granted with dma_lock_i=1 and MAX_DMA_BURST>1; burst_cnt := 1.
  - In DMA_BURST, each DMA grant increments burst_cnt. The state stays while dma_en_i & dma_lock_i & burst_cnt < MAX_DMA_BURST.
  - DMA_BURST -> ARB when dma_en_i=0, dma_lock_i=0, or burst_cnt reaches MAX_DMA_BURST.
  - On exit due to the burst limit, the next cycle gives CPU priority regardless of cpu_streak (1-cycle release flag). If the CPU is idle that cycle, DMA may be granted again.
  - DMA_BURST with dma_en_i=0 and cpu_en_i=1: CPU is granted and the state goes to ARB.
- Read return:
  - A granted access with we=0 registers {owner, read} into a 1-deep tag.
  - Next cycle, the owner's rvalid=1 and its rdata = mem_rdata_i. The other master's rdata is 0.
  - Writes never raise rvalid.
  - Back-to-back reads from alternating owners return in grant order, one per cycle.
- Simultaneous events: a read return to one master and a new grant to the other occur in the same cycle without conflict.
- Reset (reset=0), asynchronous:
  - State := ARB; cpu_streak := 0; burst_cnt := 0; release flag := 0; read tag cleared.
  - All registered outputs 0 (cpu_rvalid_o, dma_rvalid_o, rdata outputs 0).
  - Combinational outputs follow inputs with state ARB.
  - A read granted in the cycle before reset asserts never returns rvalid.
- Counter widths: cpu_streak is 4 bits; burst_cnt is 8 bits. No wrap: both saturate or clear as above.

Test Plan:
- Reset: reset=0 with both masters requesting reads -> after release, first cycle CPU granted (mem_addr_o=cpu_addr_i), cpu_stall_o=0, dma_gnt_o=0; both rvalid=0 during reset.
- Starvation bound (MAX_CPU_STREAK=4): CPU and DMA request continuously, no lock -> grant pattern C,C,C,C,D repeating; cpu_stall_o=1 exactly on D cycles.
- Burst lock (MAX_DMA_BURST=8): DMA requests with dma_lock_i=1 from an idle CPU; CPU requests from the 2nd beat -> 8 consecutive DMA grants, then CPU granted on cycle 9, cpu_stall_o=1 on cycles 2..8.
- Early unlock: dma_lock_i drops after beat 3 with the CPU waiting -> CPU granted on cycle 4; state ARB.
- Read routing: CPU reads 0x100 (memory returns 0xDEADBEEF), then DMA reads 0x200 (memory returns 0x12345678) the next cycle -> cpu_rvalid_o=1 with 0xDEADBEEF at t+1; dma_rvalid_o=1 with 0x12345678 at t+2; the other rvalid stays 0.
- Reset mid-read: DMA read granted, reset asserted next cycle -> dma_rvalid_o stays 0; after release no stale return.
